axi_nap_reg_initiator: RTL and testbench

- Fabric-side AXI4 initiator that turns simple single-word register commands (read or write) into single-beat AXI4 transactions.
- Its AXI port drives a slave NAP, so fabric logic can reach register sets and memories elsewhere on the NoC.
- It is the requesting end of the same AXI protocol that NoC-attached register slaves answer.
- One transaction is outstanding at a time. Each completed transaction returns exactly one response word with status, plus saturating statistics counters.

---
 rtl/axi_nap_reg_init_pkg.sv | 27 ++
 rtl/acx_sat_counter.sv | 30 +++
 rtl/axi_nap_reg_initiator.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_nap_reg_initiator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_nap_reg_init_pkg.sv
// Shared types and constants for the AXI register initiator.
//   t_init_state : transaction FSM state encoding
//   AXI_*        : burst type and response codes used on the AXI port
//   axi_size()   : AXI size code (log2 of bytes per beat) for a data width
package axi_nap_reg_init_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } t_init_state;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Size code for a full-width beat: log2(width/8).
    function automatic logic [2:0] axi_size(input int width);
        int bytes;
        bytes = width / 8;
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/acx_sat_counter.sv
// Saturating up-counter for transaction statistics.
//   clk     : clock
//   reset_n : asynchronous active-low reset, clears the count
//   inc     : count one event this cycle
//   count   : current value, sticks at all-ones instead of wrapping
module acx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count events, holding at the maximum value once reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/axi_nap_reg_initiator.sv
// Fabric-side AXI4 initiator: converts single-word register commands into
// single-beat AXI4 transactions, one outstanding at a time, and returns one
// response word per transaction plus saturating statistics.
//   i_clk, i_reset_n     : clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready: command (write flag, byte address, data, strobes)
//   o_rsp_* / i_rsp_ready: response (write flag, read data, resp, id error)
//   o_wr/rd/err_count    : saturating completed-write/read/error counts
//   AW/W/B/AR/R          : AXI4 master channels toward a slave NAP
module axi_nap_reg_initiator
    import axi_nap_reg_init_pkg::*;
#(
    parameter int                  DATA_WIDTH = 256,
    parameter int                  ADDR_WIDTH = 42,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = 8'h00,
    parameter int                  CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_write,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_id_err,
    output logic [CNT_WIDTH-1:0]    o_wr_count,
    output logic [CNT_WIDTH-1:0]    o_rd_count,
    output logic [CNT_WIDTH-1:0]    o_err_count,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [ID_WIDTH-1:0]     o_awid,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [ID_WIDTH-1:0]     o_arid,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [ID_WIDTH-1:0]     i_rid,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast
);

    localparam logic [2:0] BEAT_SIZE = axi_size(DATA_WIDTH);

    t_init_state             state_r;
    logic                    cmd_ready_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    arvalid_r;
    logic                    bready_r;
    logic                    rready_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    rsp_valid_r;
    logic                    rsp_write_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]              rsp_resp_r;
    logic                    rsp_id_err_r;

    logic bid_err_s;
    logic rid_err_s;
    logic aw_done_s;
    logic w_done_s;
    logic rsp_hs_s;
    logic wr_inc_s;
    logic rd_inc_s;
    logic err_inc_s;
    logic unused_s;

    // Single-beat transfers always end with their only beat.
    assign unused_s  = i_rlast;

    assign bid_err_s = (i_bid != AXI_ID);
    assign rid_err_s = (i_rid != AXI_ID);

    // A write channel counts as done once its valid is low or handshaking now.
    assign aw_done_s = !awvalid_r || i_awready;
    assign w_done_s  = !wvalid_r || i_wready;

    assign rsp_hs_s  = rsp_valid_r && i_rsp_ready;
    assign wr_inc_s  = rsp_hs_s && rsp_write_r;
    assign rd_inc_s  = rsp_hs_s && !rsp_write_r;
    assign err_inc_s = rsp_hs_s && ((rsp_resp_r != AXI_RESP_OKAY) || rsp_id_err_r);

    // Transaction FSM with all AXI and response outputs registered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= IDLE;
            cmd_ready_r  <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            bready_r     <= 1'b0;
            rready_r     <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_write_r  <= 1'b0;
            rsp_rdata_r  <= '0;
            rsp_resp_r   <= 2'b00;
            rsp_id_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_ready_r && i_cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        addr_r      <= i_cmd_addr;
                        wdata_r     <= i_cmd_wdata;
                        wstrb_r     <= i_cmd_wstrb;
                        if (i_cmd_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_REQ;
                        end
                    end else begin
                        // Ready rises one cycle after reset or a response.
                        cmd_ready_r <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (awvalid_r && i_awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && i_wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (i_bvalid) begin
                        bready_r     <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_write_r  <= 1'b1;
                        rsp_rdata_r  <= '0;
                        rsp_id_err_r <= bid_err_s;
                        rsp_resp_r   <= bid_err_s ? AXI_RESP_SLVERR : i_bresp;
                        state_r      <= RSP;
                    end
                end
                RD_REQ: begin
                    if (i_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (i_rvalid) begin
                        rready_r     <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_write_r  <= 1'b0;
                        rsp_rdata_r  <= i_rdata;
                        rsp_id_err_r <= rid_err_s;
                        rsp_resp_r   <= rid_err_s ? AXI_RESP_SLVERR : i_rresp;
                        state_r      <= RSP;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_r <= 1'b0;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    acx_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk(i_clk), .reset_n(i_reset_n), .inc(wr_inc_s), .count(o_wr_count)
    );
    acx_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk(i_clk), .reset_n(i_reset_n), .inc(rd_inc_s), .count(o_rd_count)
    );
    acx_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(i_clk), .reset_n(i_reset_n), .inc(err_inc_s), .count(o_err_count)
    );

    assign o_cmd_ready  = cmd_ready_r;
    assign o_rsp_valid  = rsp_valid_r;
    assign o_rsp_write  = rsp_write_r;
    assign o_rsp_rdata  = rsp_rdata_r;
    assign o_rsp_resp   = rsp_resp_r;
    assign o_rsp_id_err = rsp_id_err_r;

    assign o_awvalid = awvalid_r;
    assign o_awaddr  = addr_r;
    assign o_awid    = AXI_ID;
    assign o_awlen   = 8'd0;
    assign o_awsize  = BEAT_SIZE;
    assign o_awburst = AXI_BURST_INCR;
    assign o_wvalid  = wvalid_r;
    assign o_wdata   = wdata_r;
    assign o_wstrb   = wstrb_r;
    assign o_wlast   = 1'b1;
    assign o_bready  = bready_r;
    assign o_arvalid = arvalid_r;
    assign o_araddr  = addr_r;
    assign o_arid    = AXI_ID;
    assign o_arlen   = 8'd0;
    assign o_arsize  = BEAT_SIZE;
    assign o_arburst = AXI_BURST_INCR;
    assign o_rready  = rready_r;

endmodule

// File: tb/tb_axi_nap_reg_initiator.sv
module tb_axi_nap_reg_initiator;

    localparam int DW = 256;
    localparam int AW = 42;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [31:0]   wstrb;
        int            a_dly;
        int            w_dly;
        int            r_dly;
        int            rdy_dly;
        logic [1:0]    sresp;
        logic [7:0]    sid;
        logic [DW-1:0] srdata;
        logic [1:0]    exp_resp;
        logic          exp_id_err;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic i_reset_n;
    logic i_cmd_valid, i_cmd_write, i_rsp_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata, i_rdata;
    logic [31:0] i_cmd_wstrb;
    logic i_awready, i_wready, i_bvalid, i_arready, i_rvalid, i_rlast;
    logic [7:0] i_bid, i_rid;
    logic [1:0] i_bresp, i_rresp;

    logic o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_id_err;
    logic [DW-1:0] o_rsp_rdata, o_wdata;
    logic [1:0] o_rsp_resp, o_awburst, o_arburst;
    logic [15:0] o_wr_count, o_rd_count, o_err_count;
    logic o_awvalid, o_wvalid, o_wlast, o_bready, o_arvalid, o_rready;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [7:0] o_awid, o_arid, o_awlen, o_arlen;
    logic [2:0] o_awsize, o_arsize;
    logic [31:0] o_wstrb;

    logic n_cmd_ready, n_rsp_valid, n_rsp_write, n_rsp_id_err;
    logic [DW-1:0] n_rsp_rdata, n_wdata;
    logic [1:0] n_rsp_resp, n_awburst, n_arburst;
    logic [1:0] n_wr_count, n_rd_count, n_err_count;
    logic n_awvalid, n_wvalid, n_wlast, n_bready, n_arvalid, n_rready;
    logic [AW-1:0] n_awaddr, n_araddr;
    logic [7:0] n_awid, n_arid, n_awlen, n_arlen;
    logic [2:0] n_awsize, n_arsize;
    logic [31:0] n_wstrb;

    logic [9:0] ctl_s;
    assign ctl_s = {o_cmd_ready, o_awvalid, o_wvalid, o_arvalid, o_bready,
                    o_rready, o_rsp_valid, o_rsp_write, o_rsp_id_err, o_rsp_resp[0] | o_rsp_resp[1]};

    int errors = 0;
    int checks = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    axi_nap_reg_initiator dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_rsp_id_err(o_rsp_id_err),
        .o_wr_count(o_wr_count), .o_rd_count(o_rd_count), .o_err_count(o_err_count),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awid(o_awid),
        .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arid(o_arid),
        .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rid(i_rid),
        .i_rresp(i_rresp), .i_rlast(i_rlast)
    );

    // Same stimulus, 2-bit counters to reach saturation quickly.
    axi_nap_reg_initiator #(.CNT_WIDTH(2)) dut_sat (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(n_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(n_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(n_rsp_write),
        .o_rsp_rdata(n_rsp_rdata), .o_rsp_resp(n_rsp_resp), .o_rsp_id_err(n_rsp_id_err),
        .o_wr_count(n_wr_count), .o_rd_count(n_rd_count), .o_err_count(n_err_count),
        .o_awvalid(n_awvalid), .i_awready(i_awready), .o_awaddr(n_awaddr), .o_awid(n_awid),
        .o_awlen(n_awlen), .o_awsize(n_awsize), .o_awburst(n_awburst),
        .o_wvalid(n_wvalid), .i_wready(i_wready), .o_wdata(n_wdata), .o_wstrb(n_wstrb), .o_wlast(n_wlast),
        .i_bvalid(i_bvalid), .o_bready(n_bready), .i_bid(i_bid), .i_bresp(i_bresp),
        .o_arvalid(n_arvalid), .i_arready(i_arready), .o_araddr(n_araddr), .o_arid(n_arid),
        .o_arlen(n_arlen), .o_arsize(n_arsize), .o_arburst(n_arburst),
        .i_rvalid(i_rvalid), .o_rready(n_rready), .i_rdata(i_rdata), .i_rid(i_rid),
        .i_rresp(i_rresp), .i_rlast(i_rlast)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    function automatic vec_t mkv(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [31:0] wstrb, input int a_dly, input int w_dly,
                                 input int r_dly, input int rdy_dly, input logic [1:0] sresp,
                                 input logic [7:0] sid, input logic [DW-1:0] srdata,
                                 input logic [1:0] exp_resp, input logic exp_id_err,
                                 input logic [DW-1:0] exp_rdata, input int exp_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.a_dly = a_dly; v.w_dly = w_dly; v.r_dly = r_dly; v.rdy_dly = rdy_dly;
        v.sresp = sresp; v.sid = sid; v.srdata = srdata;
        v.exp_resp = exp_resp; v.exp_id_err = exp_id_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic idle_slave();
        i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
        i_bvalid = 1'b0; i_rvalid = 1'b0; i_rsp_ready = 1'b0;
    endtask

    // Issue one command, play the slave with the vector's delays, check everything.
    task automatic run_txn(input int idx, input vec_t v);
        int aw_n, w_n, b_n, rv_c, d_c, to, proto, hold;
        logic done;
        string p;
        p = $sformatf("v%0d_", idx);
        to = 0;
        while (!o_cmd_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk({p, "cmd_ready"}, DW'(o_cmd_ready), DW'(1));
        i_cmd_valid = 1'b1; i_cmd_write = v.wr; i_cmd_addr = v.addr;
        i_cmd_wdata = v.wdata; i_cmd_wstrb = v.wstrb;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        aw_n = 0; w_n = 0; b_n = 0; rv_c = -1; d_c = -1; proto = 0; hold = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (v.wr) begin
                if (o_awvalid !== (aw_n == 0)) proto++;
                if (o_wvalid !== (w_n == 0)) proto++;
                if (o_arvalid !== 1'b0) proto++;
                if (o_awvalid && o_awaddr !== v.addr) proto++;
                if (o_wvalid && (o_wdata !== v.wdata || o_wstrb !== v.wstrb)) proto++;
                i_awready = (aw_n == 0) && (c >= v.a_dly);
                i_wready  = (w_n == 0) && (c >= v.w_dly);
                if (o_awvalid && i_awready) aw_n++;
                if (o_wvalid && i_wready) w_n++;
                if (aw_n > 0 && w_n > 0 && d_c < 0) d_c = c;
                i_bvalid = (d_c >= 0) && (b_n == 0) && (c >= d_c + 1 + v.r_dly);
                i_bresp = v.sresp; i_bid = v.sid;
                if (i_bvalid && o_bready) b_n++;
            end else begin
                if (o_arvalid !== (aw_n == 0)) proto++;
                if (o_awvalid !== 1'b0 || o_wvalid !== 1'b0) proto++;
                if (o_arvalid && o_araddr !== v.addr) proto++;
                i_arready = (aw_n == 0) && (c >= v.a_dly);
                if (o_arvalid && i_arready) begin
                    aw_n++;
                    d_c = c;
                end
                i_rvalid = (d_c >= 0) && (b_n == 0) && (c >= d_c + 1 + v.r_dly);
                i_rdata = v.srdata; i_rid = v.sid; i_rresp = v.sresp; i_rlast = 1'b1;
                if (i_rvalid && o_rready) b_n++;
            end
            if (o_rsp_valid) begin
                if (rv_c < 0) rv_c = c;
                i_rsp_ready = (c >= rv_c + v.rdy_dly);
                if (o_rsp_rdata !== v.exp_rdata || o_rsp_resp !== v.exp_resp ||
                    o_rsp_id_err !== v.exp_id_err || o_cmd_ready !== 1'b0) hold++;
                if (i_rsp_ready) begin
                    done = 1'b1;
                    chk({p, "rsp_write"}, DW'(o_rsp_write), DW'(v.wr));
                    chk({p, "rsp_resp"}, DW'(o_rsp_resp), DW'(v.exp_resp));
                    chk({p, "rsp_id_err"}, DW'(o_rsp_id_err), DW'(v.exp_id_err));
                    chk({p, "rsp_rdata"}, o_rsp_rdata, v.exp_rdata);
                end
            end else begin
                i_rsp_ready = 1'b0;
            end
            @(negedge clk);
        end
        idle_slave();
        chk({p, "completed"}, DW'(done), DW'(1));
        chk({p, "addr_hs"}, DW'(aw_n), DW'(1));
        if (v.wr) chk({p, "w_hs"}, DW'(w_n), DW'(1));
        chk({p, "resp_hs"}, DW'(b_n), DW'(1));
        chk({p, "chan_protocol"}, DW'(proto), DW'(0));
        chk({p, "rsp_hold"}, DW'(hold), DW'(0));
        if (v.exp_lat > 0) chk({p, "latency"}, DW'(rv_c + 1), DW'(v.exp_lat));
        if (v.wr) exp_wr++; else exp_rd++;
        if (v.exp_resp != 2'b00 || v.exp_id_err) exp_err++;
        chk({p, "wr_count"}, DW'(o_wr_count), DW'(exp_wr));
        chk({p, "rd_count"}, DW'(o_rd_count), DW'(exp_rd));
        chk({p, "err_count"}, DW'(o_err_count), DW'(exp_err));
        chk({p, "sat_wr_count"}, DW'(n_wr_count), DW'(sat3(exp_wr)));
        chk({p, "sat_rd_count"}, DW'(n_rd_count), DW'(sat3(exp_rd)));
        chk({p, "sat_err_count"}, DW'(n_err_count), DW'(sat3(exp_err)));
    endtask

    initial begin
        logic [DW-1:0] a5, one_s;
        int to, stale;
        a5 = {32{8'hA5}};
        one_s = 256'h1234;
        //            wr    addr       wdata               wstrb          aw w  rsp rdy sresp  sid    srdata                   exp    iderr  exp_rdata               lat
        vecs[0] = mkv(1'b1, 42'h100, a5,                  32'hFFFF_FFFF, 0, 0, 0, 0, 2'b00, 8'h00, '0,                     2'b00, 1'b0, '0,                     3);
        vecs[1] = mkv(1'b1, 42'h104, {32{8'h3C}},         32'h0000_000F, 5, 0, 0, 0, 2'b00, 8'h00, '0,                     2'b00, 1'b0, '0,                     8);
        vecs[2] = mkv(1'b1, 42'h108, {16{16'hBEEF}},      32'hF000_0000, 0, 5, 0, 0, 2'b00, 8'h00, '0,                     2'b00, 1'b0, '0,                     8);
        vecs[3] = mkv(1'b1, 42'h10C, {8{32'h0123_4567}},  32'hFFFF_FFFF, 2, 2, 2, 0, 2'b10, 8'h00, '0,                     2'b10, 1'b0, '0,                     7);
        vecs[4] = mkv(1'b0, 42'h200, '0,                  32'h0,         0, 0, 4, 3, 2'b00, 8'h00, one_s,                  2'b00, 1'b0, one_s,                  7);
        vecs[5] = mkv(1'b0, 42'h204, '0,                  32'h0,         0, 0, 0, 0, 2'b00, 8'h05, 256'hCAFE,              2'b10, 1'b1, 256'hCAFE,              3);
        vecs[6] = mkv(1'b1, 42'h300, {32{8'h5A}},         32'hFFFF_FFFF, 0, 0, 0, 1, 2'b00, 8'h07, '0,                     2'b10, 1'b1, '0,                     3);
        vecs[7] = mkv(1'b0, 42'h3FF_FFFF_FFC0, '0,        32'h0,         0, 0, 0, 0, 2'b11, 8'h00, {8{32'hDEAD_BEEF}},     2'b11, 1'b0, {8{32'hDEAD_BEEF}},     3);
        vecs[8] = mkv(1'b0, 42'h208, '0,                  32'h0,         0, 0, 0, 0, 2'b00, 8'h00, 256'h55,                2'b00, 1'b0, 256'h55,                3);
        for (int k = 0; k < 5; k++) begin
            vecs[9 + k] = mkv(1'b0, 42'h400 + 42'(4 * k), '0, 32'h0, 0, 0, 0, 0, 2'b10, 8'h00,
                              DW'(k + 1), 2'b10, 1'b0, DW'(k + 1), 3);
        end

        i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
        i_cmd_wdata = '0; i_cmd_wstrb = '0; i_bid = '0; i_bresp = '0; i_rid = '0;
        i_rresp = '0; i_rdata = '0; i_rlast = 1'b1;
        idle_slave();
        repeat (3) @(negedge clk);
        chk("reset_ctl", DW'(ctl_s), DW'(0));
        chk("reset_counts", DW'({o_wr_count, o_rd_count, o_err_count}), DW'(0));
        chk("reset_rdata", o_rsp_rdata, '0);
        chk("const_outputs", DW'({o_awlen, o_arlen, o_awsize, o_arsize, o_awburst, o_arburst, o_wlast, o_awid, o_arid}),
            DW'({8'd0, 8'd0, 3'd5, 3'd5, 2'b01, 2'b01, 1'b1, 8'h00, 8'h00}));
        i_reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Reset while waiting for the write response.
        to = 0;
        while (!o_cmd_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 42'h500;
        i_cmd_wdata = a5; i_cmd_wstrb = 32'hFFFF_FFFF;
        @(negedge clk);
        i_cmd_valid = 1'b0; i_awready = 1'b1; i_wready = 1'b1;
        to = 0;
        while (!o_bready && to < 10) begin
            @(negedge clk);
            to++;
        end
        chk("mid_reach_wr_resp", DW'(o_bready), DW'(1));
        i_awready = 1'b0; i_wready = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("mid_reset_ctl", DW'(ctl_s), DW'(0));
        chk("mid_reset_counts", DW'({o_wr_count, o_rd_count, o_err_count}), DW'(0));
        chk("mid_reset_addr", DW'(o_awaddr), DW'(0));
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_rsp_valid || o_bready || o_awvalid) stale++;
        end
        chk("no_stale_rsp", DW'(stale), DW'(0));

        for (int i = 8; i < 14; i++) run_txn(i, vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
